// File: rtl/johnson_counter_pkg.sv
// johnson_counter_pkg: Johnson code constants and one-hot load decoding shared by the counter and decoder benches.
package johnson_counter_pkg;
    localparam logic [2:0] J_POS0  = 3'b000;
    localparam logic [2:0] J_POS1  = 3'b001;
    localparam logic [2:0] J_POS2  = 3'b011;
    localparam logic [2:0] J_POS3  = 3'b111;
    localparam logic [2:0] J_POS4  = 3'b110;
    localparam logic [2:0] J_POS5  = 3'b100;
    localparam logic [2:0] J_ILL_A = 3'b010;
    localparam logic [2:0] J_ILL_B = 3'b101;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } onehot_t;

    function automatic onehot_t onehot_valid(input logic [5:0] v);
        onehot_t r;
        r.valid = ($countones(v) == 1);
        r.idx   = '0;
        for (int k = 0; k < 6; k++)
            if (v[k]) r.idx = 3'(k);
        return r;
    endfunction

    function automatic logic [2:0] pos_to_sel(input logic [2:0] p);
        return p == 3'd0 ? J_POS0 : p == 3'd1 ? J_POS1 : p == 3'd2 ? J_POS2 :
               p == 3'd3 ? J_POS3 : p == 3'd4 ? J_POS4 : J_POS5;
    endfunction
endpackage

// File: rtl/johnson_counter_if.sv
// johnson_counter_if: control inputs and status outputs of the Johnson counter.
interface johnson_counter_if;
    logic       enable;
    logic       up;
    logic       load;
    logic [5:0] load_onehot;
    logic [2:0] sel;
    logic [2:0] pos;
    logic       wrap;
    logic       load_err;
    logic       state_err;

    modport master (output enable, up, load, load_onehot,
                    input  sel, pos, wrap, load_err, state_err);
    modport slave  (input  enable, up, load, load_onehot,
                    output sel, pos, wrap, load_err, state_err);
endinterface

// File: rtl/johnson_counter_step.sv
// johnson_step: next Johnson code in the chosen direction and whether that step wraps.
module johnson_step
    import johnson_counter_pkg::*;
(
    input  logic [2:0] i_sel,
    input  logic       i_up,
    output logic [2:0] o_sel_next,
    output logic       o_wrap_next
);
    always_comb begin
        o_sel_next  = i_up ? {i_sel[1:0], ~i_sel[2]} : {~i_sel[0], i_sel[2:1]};
        o_wrap_next = i_up ? (i_sel == J_POS5) : (i_sel == J_POS0);
    end
endmodule

// File: rtl/johnson_counter.sv
// johnson_counter: prescaled up/down 6-state Johnson sequencer with one-hot load and illegal-code recovery.
module johnson_counter
    import johnson_counter_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    johnson_counter_if.slave bus
);
    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

    logic [2:0] r_sel, r_pos;
    logic [7:0] r_tick;
    logic       r_wrap, r_load_err, r_state_err;
    logic [2:0] w_sel_next, w_pos_next;
    logic       w_wrap_next, w_illegal, w_due;
    onehot_t    w_oh;

    johnson_step u_step (
        .i_sel       (r_sel),
        .i_up        (bus.up),
        .o_sel_next  (w_sel_next),
        .o_wrap_next (w_wrap_next)
    );

    always_comb begin
        w_illegal  = (r_sel == J_ILL_A) || (r_sel == J_ILL_B);
        w_oh       = onehot_valid(bus.load_onehot);
        w_due      = r_tick == TICK_LAST;
        w_pos_next = bus.up ? (r_pos == 3'd5 ? 3'd0 : r_pos + 3'd1)
                            : (r_pos == 3'd0 ? 3'd5 : r_pos - 3'd1);
    end

    // Priority: recovery > load > step; status pulses default low every cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel       <= J_POS0;
            r_pos       <= 3'd0;
            r_tick      <= 8'd0;
            r_wrap      <= 1'b0;
            r_load_err  <= 1'b0;
            r_state_err <= 1'b0;
        end else begin
            r_wrap      <= 1'b0;
            r_load_err  <= 1'b0;
            r_state_err <= 1'b0;
            if (w_illegal) begin
                r_sel       <= J_POS0;
                r_pos       <= 3'd0;
                r_tick      <= 8'd0;
                r_state_err <= 1'b1;
            end else if (bus.load) begin
                if (w_oh.valid) begin
                    r_sel  <= pos_to_sel(w_oh.idx);
                    r_pos  <= w_oh.idx;
                    r_tick <= 8'd0;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (bus.enable) begin
                if (w_due) begin
                    r_sel  <= w_sel_next;
                    r_pos  <= w_pos_next;
                    r_tick <= 8'd0;
                    r_wrap <= w_wrap_next;
                end else begin
                    r_tick <= r_tick + 8'd1;
                end
            end
        end
    end

    assign bus.sel       = r_sel;
    assign bus.pos       = r_pos;
    assign bus.wrap      = r_wrap;
    assign bus.load_err  = r_load_err;
    assign bus.state_err = r_state_err;
endmodule

// File: tb/tb_johnson_counter.sv
// tb_johnson_counter: directed checks of stepping, prescale, load, recovery and async reset.
module tb_johnson_counter;
    logic clk = 1'b0;
    logic rst1_n = 1'b0;
    logic rst3_n = 1'b0;
    int checks = 0;
    int failures = 0;

    johnson_counter_if bus1 ();
    johnson_counter_if bus3 ();

    johnson_counter #(.TICK_DIV(1)) dut1 (.clk(clk), .reset_n(rst1_n), .bus(bus1.slave));
    johnson_counter #(.TICK_DIV(3)) dut3 (.clk(clk), .reset_n(rst3_n), .bus(bus3.slave));

    always #5 clk = ~clk;

    logic [2:0] seq [6] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b110, 3'b100};

    task automatic test_reset;
        bus1.enable = 1'b1; bus1.up = 1'b1; bus1.load = 1'b0; bus1.load_onehot = 6'd0;
        bus3.enable = 1'b0; bus3.up = 1'b1; bus3.load = 1'b0; bus3.load_onehot = 6'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus1.sel, bus1.pos, bus1.wrap, bus1.load_err, bus1.state_err} !== 9'd0) begin
            failures++;
            $display("FAIL reset_state got sel=%b pos=%0d wrap=%b le=%b se=%b want all zero",
                     bus1.sel, bus1.pos, bus1.wrap, bus1.load_err, bus1.state_err);
        end
        rst1_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checks++;
            if (bus1.sel !== seq[i % 6] || bus1.pos !== 3'(i % 6) || bus1.wrap !== (i == 6)) begin
                failures++;
                $display("FAIL fwd_step%0d got sel=%b pos=%0d wrap=%b want sel=%b pos=%0d wrap=%b",
                         i, bus1.sel, bus1.pos, bus1.wrap, seq[i % 6], i % 6, i == 6);
            end
        end
    endtask

    task automatic test_reverse;
        bus1.up = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checks++;
            if (bus1.sel !== seq[(6 - i) % 6] || bus1.pos !== 3'((6 - i) % 6) || bus1.wrap !== (i == 1)) begin
                failures++;
                $display("FAIL rev_step%0d got sel=%b pos=%0d wrap=%b want sel=%b pos=%0d wrap=%b",
                         i, bus1.sel, bus1.pos, bus1.wrap, seq[(6 - i) % 6], (6 - i) % 6, i == 1);
            end
        end
        bus1.enable = 1'b0;
    endtask

    task automatic test_prescale;
        logic [2:0] want;
        bus3.enable = 1'b1;
        rst3_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            want = (k >= 11) ? 3'b011 : (k >= 3) ? 3'b001 : 3'b000;
            checks++;
            if (bus3.sel !== want) begin
                failures++;
                $display("FAIL prescale_k%0d got sel=%b want sel=%b", k, bus3.sel, want);
            end
            if (k == 4) bus3.enable = 1'b0;
            if (k == 9) bus3.enable = 1'b1;
        end
        checks++;
        if (bus3.pos !== 3'd2) begin
            failures++;
            $display("FAIL prescale_pos got pos=%0d want pos=2", bus3.pos);
        end
        bus3.enable = 1'b0;
    endtask

    task automatic test_load;
        bus3.load = 1'b1; bus3.load_onehot = 6'b010000;
        @(negedge clk);
        checks++;
        if (bus3.sel !== 3'b110 || bus3.pos !== 3'd4 || bus3.wrap !== 1'b0 || bus3.load_err !== 1'b0) begin
            failures++;
            $display("FAIL load_pos4 got sel=%b pos=%0d wrap=%b le=%b want sel=110 pos=4 wrap=0 le=0",
                     bus3.sel, bus3.pos, bus3.wrap, bus3.load_err);
        end
        bus3.load_onehot = 6'b000110;
        @(negedge clk);
        checks++;
        if (bus3.sel !== 3'b110 || bus3.pos !== 3'd4 || bus3.load_err !== 1'b1) begin
            failures++;
            $display("FAIL load_multi got sel=%b pos=%0d le=%b want sel=110 pos=4 le=1",
                     bus3.sel, bus3.pos, bus3.load_err);
        end
        bus3.load = 1'b0;
        @(negedge clk);
        checks++;
        if (bus3.load_err !== 1'b0) begin
            failures++;
            $display("FAIL load_err_pulse got le=%b want le=0", bus3.load_err);
        end
        bus3.load = 1'b1; bus3.load_onehot = 6'b000000;
        @(negedge clk);
        checks++;
        if (bus3.sel !== 3'b110 || bus3.load_err !== 1'b1) begin
            failures++;
            $display("FAIL load_zero got sel=%b le=%b want sel=110 le=1", bus3.sel, bus3.load_err);
        end
        bus3.load = 1'b0; bus3.enable = 1'b1;
        repeat (2) @(negedge clk);
        bus3.load = 1'b1; bus3.load_onehot = 6'b000001;
        @(negedge clk);
        checks++;
        if (bus3.sel !== 3'b000 || bus3.pos !== 3'd0 || bus3.wrap !== 1'b0) begin
            failures++;
            $display("FAIL load_beats_step got sel=%b pos=%0d wrap=%b want sel=000 pos=0 wrap=0",
                     bus3.sel, bus3.pos, bus3.wrap);
        end
        bus3.load = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus3.sel !== 3'b000) begin
            failures++;
            $display("FAIL load_clears_tick got sel=%b want sel=000", bus3.sel);
        end
        @(negedge clk);
        checks++;
        if (bus3.sel !== 3'b001 || bus3.pos !== 3'd1) begin
            failures++;
            $display("FAIL step_after_load got sel=%b pos=%0d want sel=001 pos=1", bus3.sel, bus3.pos);
        end
        bus3.enable = 1'b0;
    endtask

    task automatic test_recovery;
        bus1.load = 1'b1; bus1.load_onehot = 6'b000100;
        @(negedge clk);
        checks++;
        if (bus1.sel !== 3'b011 || bus1.pos !== 3'd2) begin
            failures++;
            $display("FAIL recov_preload got sel=%b pos=%0d want sel=011 pos=2", bus1.sel, bus1.pos);
        end
        bus1.load_onehot = 6'b001000; bus1.enable = 1'b1; bus1.up = 1'b1;
        force dut1.r_sel = 3'b101;
        #1 release dut1.r_sel;
        @(negedge clk);
        checks++;
        if (bus1.sel !== 3'b000 || bus1.pos !== 3'd0 || bus1.state_err !== 1'b1 ||
            bus1.wrap !== 1'b0 || bus1.load_err !== 1'b0) begin
            failures++;
            $display("FAIL recovery got sel=%b pos=%0d se=%b wrap=%b le=%b want sel=000 pos=0 se=1 wrap=0 le=0",
                     bus1.sel, bus1.pos, bus1.state_err, bus1.wrap, bus1.load_err);
        end
        bus1.load = 1'b0; bus1.enable = 1'b0;
        @(negedge clk);
        checks++;
        if (bus1.state_err !== 1'b0 || bus1.sel !== 3'b000) begin
            failures++;
            $display("FAIL state_err_pulse got se=%b sel=%b want se=0 sel=000", bus1.state_err, bus1.sel);
        end
    endtask

    task automatic test_async_reset;
        bus3.load = 1'b1; bus3.load_onehot = 6'b001000;
        @(negedge clk);
        bus3.load = 1'b0; bus3.enable = 1'b1;
        @(negedge clk);
        checks++;
        if (bus3.sel !== 3'b111 || bus3.pos !== 3'd3) begin
            failures++;
            $display("FAIL arst_setup got sel=%b pos=%0d want sel=111 pos=3", bus3.sel, bus3.pos);
        end
        #1 rst3_n = 1'b0;
        #1;
        checks++;
        if (bus3.sel !== 3'b000 || bus3.pos !== 3'd0) begin
            failures++;
            $display("FAIL arst_immediate got sel=%b pos=%0d want sel=000 pos=0", bus3.sel, bus3.pos);
        end
        #1 rst3_n = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus3.sel !== (k == 3 ? 3'b001 : 3'b000)) begin
                failures++;
                $display("FAIL arst_restart_k%0d got sel=%b want sel=%b", k, bus3.sel,
                         k == 3 ? 3'b001 : 3'b000);
            end
        end
    endtask

    initial begin
        test_reset();
        test_reverse();
        test_prescale();
        test_load();
        test_recovery();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/johnson_counter.md
# johnson_counter

Sequential counterpart of the 3-bit Johnson-code decoder: generates the 6-state Johnson sequence that drives a decoder's `sel` input. It advances up or down on prescaled enable ticks, can be loaded from a one-hot position, reports wrap-around, and recovers from the two illegal codes. It sits upstream of the Johnson decoder in phase/step sequencers.

## Interface
- `TICK_DIV`, default 1: number of qualified `enable` cycles per step (1..255).
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `enable`  in  1  count qualifier; advances the prescaler.
- `up`  in  1  direction: 1 = forward, 0 = reverse; sampled on the step cycle.
- `load`  in  1  synchronous load request; has priority over `enable`.
- `load_onehot`  in  6  target position as a one-hot vector (bit k = position k).
- `sel`  out  3  current Johnson code, registered.
- `pos`  out  3  current position 0..5, registered and consistent with `sel`.
- `wrap`  out  1  one-cycle pulse on a 5→0 (up) or 0→5 (down) step.
- `load_err`  out  1  one-cycle pulse when a load is rejected.
- `state_err`  out  1  one-cycle pulse when an illegal code is detected and recovered.

## Operation
- Code map (pos:sel): 0:000, 1:001, 2:011, 3:111, 4:110, 5:100. Codes 010 and 101 are illegal.
- Forward step: `sel_next = {sel[1:0], ~sel[2]}`. Reverse step: `sel_next = {~sel[0], sel[2:1]}`.
- `pos` is held in a register updated together with `sel`, not decoded combinationally. `pos` wraps mod 6.
- Prescaler: 8-bit counter `tick_cnt`.
  - On each cycle with `enable=1` and no load: if `tick_cnt == TICK_DIV-1`, take a step and clear `tick_cnt`; otherwise increment `tick_cnt`.
  - With `enable=0`, `tick_cnt` holds.
- Load, when `load=1`:
  - If `load_onehot` has exactly one bit set, in bit 0..5: `sel`/`pos` take that position, `tick_cnt` clears, and no `wrap` is generated.
  - Zero bits or more than one bit set: state is unchanged, `tick_cnt` is unchanged, and `load_err` pulses next cycle.
  - A load overrides any step in the same cycle.
- Illegal-state recovery: if `sel` holds 010 or 101 (e.g. after an SEU or a forced value):
  - The next clock forces `sel=000`, `pos=0`, clears `tick_cnt`, and pulses `state_err`.
  - Recovery overrides both load and step.
  - The forced recovery produces no `wrap`.
- `wrap` pulses only on a genuine step: forward from pos 5, or reverse from pos 0.

## Timing
- Reset values (asynchronous, immediate): `sel=000`, `pos=0`, `tick_cnt=0`, `wrap=0`, `load_err=0`, `state_err=0`.
- Step latency: `sel`/`pos` change on the clock edge that samples the TICK_DIV-th `enable`. With `TICK_DIV=1`, every enabled cycle steps.
- `wrap`, `load_err` and `state_err` are registered. Each is asserted in the same cycle the new `sel` appears (i.e. one edge after the causing input) and is high for exactly one cycle.
- Simultaneous events:
  - Priority order is recovery > load > step.
  - `up` toggling between steps takes effect at the next step only.
- Reset asserted mid-count discards the prescaler progress. The first step after release needs the full TICK_DIV enables.

## Structure
- The shared package holds:
  - the six legal Johnson code constants;
  - the illegal code constants 010 and 101;
  - a function `onehot_valid(6-bit)` returning valid plus the encoded index, usable by both this block and the decoder's bench.
- One sub-module is natural: `johnson_step`, combinational, taking `sel` and `up` and returning `sel_next` and `wrap_next`.
- The prescaler and load logic stay in the top module.

## Test plan
- **Reset:** hold `reset_n=0`, then release with `TICK_DIV=1`, `enable=1`, `up=1` → `sel` 000,001,011,111,110,100,000. `wrap=1` in the cycle `sel` returns to 000. `pos` steps 0..5,0.
- **Reverse:** `up=0` from pos 0 → `sel` 100 with `wrap=1`, then 110, 111, 011, 001, 000.
- **Prescale:** `TICK_DIV=3`, `enable=1` continuously → `sel` changes every 3rd cycle. Dropping `enable` for 5 cycles mid-count delays the step by exactly 5 cycles.
- **Load:**
  - `load_onehot=6'b010000` → next cycle `sel=110`, `pos=4`, no `wrap`.
  - `load_onehot=6'b000110` → state held, `load_err` pulses for 1 cycle.
  - `load` and a due step in the same cycle → the load wins.
- **Recovery:** force `sel=3'b101` → next edge `sel=000`, `pos=0`, `state_err=1` for one cycle, and a simultaneous `load` is ignored.
- **Async reset mid-count:** pulse `reset_n` low between clock edges at pos 3 → `sel=000` immediately without a clock. The prescaler restarts and the first step comes after TICK_DIV enables.
